// File: rtl/eh2_lsu_bus_clken_gen_pkg.sv
// LSU bus clock-enable shared types and constants.
// Bus ratio encodings and default build parameters.
package eh2_lsu_bus_clken_gen_pkg;

  localparam int NUM_THREADS_DEF = 2;
  localparam int IDLE_HYST_DEF   = 4;

  typedef logic [2:0] bus_ratio_t;
  typedef logic [3:0] idle_cnt_t;

  localparam bus_ratio_t BUS_RATIO_1TO1 = 3'd0;
  localparam bus_ratio_t BUS_RATIO_2TO1 = 3'd1;
  localparam bus_ratio_t BUS_RATIO_4TO1 = 3'd3;
  localparam bus_ratio_t BUS_RATIO_8TO1 = 3'd7;

  function automatic logic bus_edge(
    input bus_ratio_t cnt,
    input bus_ratio_t ratio
  );
    return cnt == ratio;
  endfunction

endpackage

// File: rtl/eh2_lsu_bus_clken_gen.sv
// LSU bus-side timing qualifiers: bus clock enable,
// bus-synced force halt, halt drain and bus quiet.
module eh2_lsu_bus_clken_gen
  import eh2_lsu_bus_clken_gen_pkg::*;
#(
  parameter int NUM_THREADS = NUM_THREADS_DEF,
  parameter int IDLE_HYST   = IDLE_HYST_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             bus_ratio,
  input  logic                   clk_override,
  input  logic [NUM_THREADS-1:0] dec_tlu_force_halt,
  input  logic [NUM_THREADS-1:0] lsu_bus_buffer_empty_any,
  input  logic [NUM_THREADS-1:0] lsu_bus_idle_any,
  input  logic                   lsu_busreq_dc5,
  output logic                   lsu_bus_clk_en,
  output logic [NUM_THREADS-1:0] dec_tlu_force_halt_bus,
  output logic [NUM_THREADS-1:0] lsu_halt_drained,
  output logic                   lsu_bus_quiet
);

  localparam idle_cnt_t IDLE_MAX = idle_cnt_t'(IDLE_HYST);

  bus_ratio_t             cnt_q;
  bus_ratio_t             ratio_q;
  idle_cnt_t              idle_cnt_q;
  logic [NUM_THREADS-1:0] halt_q;
  logic [NUM_THREADS-1:0] drained_q;
  logic                   quiet_cond;

  assign lsu_bus_clk_en = bus_edge(cnt_q, ratio_q);

  // Ratio counter; new ratio only loads on a bus edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 3'd0;
      ratio_q <= BUS_RATIO_1TO1;
    end else if (lsu_bus_clk_en) begin
      cnt_q   <= 3'd0;
      ratio_q <= bus_ratio;
    end else begin
      cnt_q   <= cnt_q + 3'd1;
    end
  end

  for (genvar i = 0; i < NUM_THREADS; i++) begin : g_thr
    // Halt and drain sampled on bus edges only.
    always_ff @(posedge clk) begin
      if (rst) begin
        halt_q[i]    <= 1'b0;
        drained_q[i] <= 1'b0;
      end else if (lsu_bus_clk_en) begin
        halt_q[i]    <= dec_tlu_force_halt[i];
        drained_q[i] <= halt_q[i]
                      & dec_tlu_force_halt[i]
                      & lsu_bus_buffer_empty_any[i]
                      & lsu_bus_idle_any[i];
      end
    end
  end

  assign quiet_cond = (&lsu_bus_buffer_empty_any)
                    & (&lsu_bus_idle_any)
                    & ~lsu_busreq_dc5;

  // Quiet hysteresis; any activity clears it at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q <= '0;
    end else if (!quiet_cond) begin
      idle_cnt_q <= '0;
    end else if (lsu_bus_clk_en && idle_cnt_q != IDLE_MAX) begin
      idle_cnt_q <= idle_cnt_q + 4'd1;
    end
  end

  assign lsu_bus_quiet = (idle_cnt_q == IDLE_MAX)
                       & ~clk_override
                       & ~(|halt_q);

  assign dec_tlu_force_halt_bus = halt_q;
  assign lsu_halt_drained       = drained_q;

endmodule

// File: tb/tb_eh2_lsu_bus_clken_gen.sv
// Directed bench for eh2_lsu_bus_clken_gen.
// Cycle 0 is the first cycle after reset release.
module tb_eh2_lsu_bus_clken_gen;
  import eh2_lsu_bus_clken_gen_pkg::*;

  localparam int NT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    bus_ratio = 3'd0;
  logic          clk_override = 1'b0;
  logic [NT-1:0] force_halt = '0;
  logic [NT-1:0] buf_empty = '1;
  logic [NT-1:0] bus_idle = '1;
  logic          busreq = 1'b0;
  logic          clk_en;
  logic [NT-1:0] halt_bus;
  logic [NT-1:0] drained;
  logic          quiet;

  int checks = 0;
  int failures = 0;

  eh2_lsu_bus_clken_gen #(
    .NUM_THREADS(NT),
    .IDLE_HYST(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_ratio(bus_ratio),
    .clk_override(clk_override),
    .dec_tlu_force_halt(force_halt),
    .lsu_bus_buffer_empty_any(buf_empty),
    .lsu_bus_idle_any(bus_idle),
    .lsu_busreq_dc5(busreq),
    .lsu_bus_clk_en(clk_en),
    .dec_tlu_force_halt_bus(halt_bus),
    .lsu_halt_drained(drained),
    .lsu_bus_quiet(quiet)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_ratio = 3'd0;
    clk_override = 1'b0;
    force_halt = '0;
    buf_empty = '1;
    bus_idle = '1;
    busreq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_en", 32'(clk_en), 32'd1);
    check("rst_halt", 32'(halt_bus), 32'd0);
    check("rst_drain", 32'(drained), 32'd0);
    check("rst_quiet", 32'(quiet), 32'd0);
    rst = 1'b0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Ratio 3 held, halt 5..13, drain and quiet gating
    do_reset();
    for (int c = 0; c <= 18; c++) begin
      if (c > 0) tick();
      bus_ratio = BUS_RATIO_4TO1;
      force_halt = (c >= 5 && c < 14) ? 2'b01 : 2'b00;
      #1;
      check($sformatf("r3_en_c%0d", c), 32'(clk_en),
            32'((c % 4) == 0));
      if (c >= 1 && c <= 5)
        check($sformatf("r3_cnt_c%0d", c), 32'(dut.cnt_q),
              32'((c - 1) % 4));
      check($sformatf("r3_halt_c%0d", c), 32'(halt_bus),
            (c >= 9 && c <= 16) ? 32'd1 : 32'd0);
      check($sformatf("r3_drain_c%0d", c), 32'(drained),
            (c >= 13 && c <= 16) ? 32'd1 : 32'd0);
      check($sformatf("r3_quiet_c%0d", c), 32'(quiet),
            32'(c >= 17));
    end

    // Ratio change 3 -> 1 at cycle 6, busreq in non-enable cycle
    do_reset();
    for (int c = 0; c <= 13; c++) begin
      if (c > 0) tick();
      bus_ratio = (c >= 6) ? BUS_RATIO_2TO1 : BUS_RATIO_4TO1;
      busreq = (c == 6);
      #1;
      check($sformatf("rc_en_c%0d", c), 32'(clk_en),
            32'(c == 0 || c == 4 || c == 8 || c == 10 || c == 12));
      if (c >= 11)
        check($sformatf("rc_quiet_c%0d", c), 32'(quiet), 32'd0);
    end

    // Short halt pulse between bus edges
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) tick();
      bus_ratio = BUS_RATIO_4TO1;
      force_halt = (c == 5 || c == 6) ? 2'b01 : 2'b00;
      #1;
      check($sformatf("sh_halt_c%0d", c), 32'(halt_bus), 32'd0);
    end

    // Quiet hysteresis at ratio 0
    do_reset();
    for (int c = 0; c <= 24; c++) begin
      if (c > 0) tick();
      bus_ratio = BUS_RATIO_1TO1;
      busreq = (c < 2) || (c == 8);
      clk_override = (c == 15);
      #1;
      check($sformatf("q_en_c%0d", c), 32'(clk_en), 32'd1);
      check($sformatf("q_quiet_c%0d", c), 32'(quiet),
            32'((c >= 6 && c <= 8) || (c >= 13 && c != 15)));
    end

    // Reset mid-period with ratio 7 and halt set
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) tick();
      bus_ratio = BUS_RATIO_8TO1;
      force_halt = 2'b01;
      rst = (c == 7 || c == 8);
      #1;
      if (c == 7) begin
        check("mr_pre_halt", 32'(halt_bus), 32'd1);
        check("mr_pre_en", 32'(clk_en), 32'd0);
      end
      if (c == 8) begin
        check("mr_en", 32'(clk_en), 32'd1);
        check("mr_halt", 32'(halt_bus), 32'd0);
        check("mr_drain", 32'(drained), 32'd0);
        check("mr_quiet", 32'(quiet), 32'd0);
      end
      if (c == 9) begin
        check("mr_rel_en", 32'(clk_en), 32'd1);
        check("mr_rel_halt", 32'(halt_bus), 32'd0);
      end
      if (c == 10) begin
        check("mr_post_en", 32'(clk_en), 32'd0);
        check("mr_post_halt", 32'(halt_bus), 32'd1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
